// File: rtl/xc_pshift_mc.sv
// rtl/xc_pshift_mc.sv - multi-cycle packed shift/rotate unit, one binary stage per cycle
module xc_pshift_mc #(
    parameter int XLEN = 32,
    parameter bit FAST = 1'b0
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            valid,
    input  logic            flush,
    input  logic            op_sll,
    input  logic            op_srl,
    input  logic            op_ror,
    input  logic [1:0]      pw,
    input  logic [XLEN-1:0] crs1,
    input  logic [4:0]      shamt,
    output logic            ready,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_SLL, OP_SRL, OP_ROR} op_t;

    state_t          state, state_next;
    op_t             op_q, op_in;
    logic [1:0]      pw_q;
    logic [4:0]      amt;
    logic [2:0]      cnt;
    logic [XLEN-1:0] acc, step;
    logic [4:0]      lw_m1;
    logic            accept, last;

    function automatic logic [4:0] lane_mask(input logic [1:0] p);
        case (p)
            2'b00:   lane_mask = 5'h1f;
            2'b01:   lane_mask = 5'h0f;
            2'b10:   lane_mask = 5'h07;
            default: lane_mask = 5'h03;
        endcase
    endfunction

    always_comb begin
        op_in = OP_NONE;
        if (op_ror)      op_in = OP_ROR;
        else if (op_srl) op_in = OP_SRL;
        else if (op_sll) op_in = OP_SLL;
    end

    assign accept = (state == S_IDLE) && valid && !flush;
    assign lw_m1  = lane_mask(pw_q);
    // FAST exits once no set amount bits remain above the current stage
    assign last   = (cnt == 3'd4) || (FAST && ((amt >> (cnt + 3'd1)) == 5'd0));

    always_ff @(posedge g_clk) begin
        if (!g_resetn) state <= S_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (valid) state_next = S_RUN;
            S_RUN:   if (last)  state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    // One lane-wise shift by 2^cnt; source bit index is kept inside its lane
    always_comb begin
        logic [5:0] pos, sh6, sum;
        logic [4:0] src;
        logic       keep;
        step = '0;
        sh6  = 6'd1 << cnt;
        for (int i = 0; i < XLEN; i++) begin
            pos  = 6'(i) & {1'b0, lw_m1};
            sum  = pos + sh6;
            keep = 1'b1;
            src  = 5'(i);
            case (op_q)
                OP_SLL: begin
                    keep = (pos >= sh6);
                    src  = 5'(i) - sh6[4:0];
                end
                OP_SRL: begin
                    keep = (sum <= {1'b0, lw_m1});
                    src  = 5'(i) + sh6[4:0];
                end
                OP_ROR: src = (5'(i) & ~lw_m1) | (sum[4:0] & lw_m1);
                default: ;
            endcase
            step[i] = keep & acc[src];
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            acc  <= '0;
            cnt  <= 3'd0;
            amt  <= 5'd0;
            pw_q <= 2'b00;
            op_q <= OP_NONE;
        end else if (accept) begin
            acc  <= crs1;
            cnt  <= 3'd0;
            amt  <= shamt & lane_mask(pw);
            pw_q <= pw;
            op_q <= op_in;
        end else if (state == S_RUN) begin
            if (amt[cnt]) acc <= step;
            cnt <= cnt + 3'd1;
        end
    end

    assign ready  = (state == S_DONE) && !flush && g_resetn;
    assign result = ready ? acc : '0;

endmodule

// File: tb/tb_xc_pshift_mc.sv
// tb/tb_xc_pshift_mc.sv - directed bench for xc_pshift_mc, FAST=0 and FAST=1 side by side
module tb_xc_pshift_mc;

    logic        clk = 1'b0;
    logic        resetn, valid, flush, op_sll, op_srl, op_ror;
    logic [1:0]  pw;
    logic [31:0] crs1;
    logic [4:0]  shamt;
    logic        ready0, ready1;
    logic [31:0] result0, result1;

    int total = 0, bad = 0, cyc = 0;
    int exp0_cyc = -1, exp1_cyc = -1;
    logic [31:0] exp0_res = '0, exp1_res = '0;

    xc_pshift_mc #(.XLEN(32), .FAST(1'b0)) dut0 (
        .g_clk(clk), .g_resetn(resetn), .valid(valid), .flush(flush),
        .op_sll(op_sll), .op_srl(op_srl), .op_ror(op_ror), .pw(pw),
        .crs1(crs1), .shamt(shamt), .ready(ready0), .result(result0));

    xc_pshift_mc #(.XLEN(32), .FAST(1'b1)) dut1 (
        .g_clk(clk), .g_resetn(resetn), .valid(valid), .flush(flush),
        .op_sll(op_sll), .op_srl(op_srl), .op_ror(op_ror), .pw(pw),
        .crs1(crs1), .shamt(shamt), .ready(ready1), .result(result1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
        end
    endtask

    // Whole-amount, per-lane arithmetic reference
    function automatic logic [31:0] model(input bit sl, input bit sr, input bit ro,
                                          input logic [1:0] p, input logic [31:0] x,
                                          input logic [4:0] sh);
        int w = 32 >> p;
        int a = int'(sh) & (w - 1);
        logic [63:0] mask, v, r;
        mask = (64'd1 << w) - 64'd1;
        r = '0;
        for (int l = 0; l < 32 / w; l++) begin
            v = ({32'd0, x} >> (l * w)) & mask;
            if (ro)      v = ((v >> a) | (v << (w - a))) & mask;
            else if (sr) v = v >> a;
            else if (sl) v = (v << a) & mask;
            r |= v << (l * w);
        end
        return r[31:0];
    endfunction

    function automatic int msb(input int a);
        int m = 0;
        for (int i = 0; i < 5; i++) if (((a >> i) & 1) == 1) m = i;
        return m;
    endfunction

    always @(negedge clk) begin
        chk("ready_fast0",  {31'd0, ready0}, {31'd0, cyc == exp0_cyc});
        chk("result_fast0", result0, (cyc == exp0_cyc) ? exp0_res : 32'd0);
        chk("ready_fast1",  {31'd0, ready1}, {31'd0, cyc == exp1_cyc});
        chk("result_fast1", result1, (cyc == exp1_cyc) ? exp1_res : 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic cancel_from(input int f);
        if (exp0_cyc >= f) exp0_cyc = -1;
        if (exp1_cyc >= f) exp1_cyc = -1;
    endtask

    // Presents valid for one cycle, then scrambles operands to show they were latched
    task automatic issue(input bit sl, input bit sr, input bit ro, input logic [1:0] p,
                         input logic [31:0] x, input logic [4:0] sh, output int c);
        int a;
        c = cyc;
        valid = 1'b1; op_sll = sl; op_srl = sr; op_ror = ro;
        pw = p; crs1 = x; shamt = sh;
        a = int'(sh) & ((32 >> p) - 1);
        exp0_cyc = c + 6;           exp0_res = model(sl, sr, ro, p, x, sh);
        exp1_cyc = c + 2 + msb(a);  exp1_res = exp0_res;
        step();
        valid = 1'b0;
        crs1 = $urandom; shamt = 5'($urandom); pw = 2'($urandom);
        {op_sll, op_srl, op_ror} = 3'($urandom);
    endtask

    typedef struct {
        bit sl, sr, ro;
        logic [1:0]  p;
        logic [31:0] x;
        logic [4:0]  sh;
        logic [31:0] want;
    } vec_t;

    vec_t vecs[8] = '{
        '{1'b0, 1'b0, 1'b1, 2'b01, 32'h1234_8001, 5'd4,  32'h4123_1800},
        '{1'b1, 1'b0, 1'b0, 2'b10, 32'h8181_8181, 5'd1,  32'h0202_0202},
        '{1'b0, 1'b1, 1'b0, 2'b00, 32'hF000_0000, 5'd31, 32'h0000_0001},
        '{1'b0, 1'b0, 1'b1, 2'b11, 32'h1111_1111, 5'd5,  32'h8888_8888},
        '{1'b0, 1'b0, 1'b0, 2'b01, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF},
        '{1'b1, 1'b1, 1'b1, 2'b00, 32'h8000_0001, 5'd1,  32'hC000_0000},
        '{1'b0, 1'b1, 1'b0, 2'b01, 32'hFFFF_8000, 5'd15, 32'h0001_0001},
        '{1'b1, 1'b0, 1'b0, 2'b11, 32'h1234_5678, 5'd3,  32'h8080_8080}
    };

    initial begin
        int c;
        resetn = 1'b0; valid = 1'b0; flush = 1'b0;
        op_sll = 1'b0; op_srl = 1'b0; op_ror = 1'b0;
        pw = 2'b00; crs1 = '0; shamt = '0;
        repeat (3) step();
        resetn = 1'b1;
        step();

        foreach (vecs[i])
            chk($sformatf("model_vec%0d", i),
                model(vecs[i].sl, vecs[i].sr, vecs[i].ro, vecs[i].p, vecs[i].x, vecs[i].sh),
                vecs[i].want);

        // Back-to-back: each issue lands on the cycle after the previous ready
        foreach (vecs[i]) begin
            issue(vecs[i].sl, vecs[i].sr, vecs[i].ro, vecs[i].p, vecs[i].x, vecs[i].sh, c);
            wait_until(c + 7);
        end

        // Flush mid-RUN, new op right after
        issue(1'b0, 1'b0, 1'b1, 2'b01, 32'h1234_8001, 5'd4, c);
        wait_until(c + 3);
        flush = 1'b1; cancel_from(c + 3);
        step();
        flush = 1'b0;
        issue(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_00FF, 5'd12, c);
        wait_until(c + 7);

        // Flush together with valid in IDLE accepts nothing
        valid = 1'b1; flush = 1'b1; op_srl = 1'b1; crs1 = 32'hFFFF_FFFF; shamt = 5'd3;
        step();
        valid = 1'b0; flush = 1'b0;
        repeat (8) step();

        // Valid during DONE is ignored (amount with bit 4 set: both variants take N+6)
        issue(1'b0, 1'b1, 1'b0, 2'b00, 32'hABCD_1234, 5'd16, c);
        wait_until(c + 6);
        valid = 1'b1; op_sll = 1'b1; crs1 = 32'h5555_AAAA; shamt = 5'd2;
        step();
        valid = 1'b0;
        repeat (8) step();

        // Reset mid-op, then a zero-amount op
        issue(1'b1, 1'b0, 1'b0, 2'b00, 32'h1234_5678, 5'd20, c);
        wait_until(c + 2);
        resetn = 1'b0; cancel_from(c + 2);
        step();
        resetn = 1'b1;
        issue(1'b0, 1'b0, 1'b1, 2'b10, 32'hCAFE_F00D, 5'd0, c);
        wait_until(c + 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
